product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_if.sv | 31 +++
 rtl/product_accumulator.sv | 99 +++++++++
 tb/tb_product_accumulator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Product-accumulator bus: burst control, product stream in, result out.
// Revision: 1.0
`default_nettype none

interface product_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic [8:0]       prod_i;
  logic             prod_valid_i;
  logic             prod_ready_o;
  logic [ACC_W-1:0] acc_o;
  logic             acc_valid_o;
  logic             acc_ready_i;
  logic             busy_o;
  logic             ovf_o;

  modport slave (
    input  start_i, len_i, prod_i, prod_valid_i, acc_ready_i,
    output prod_ready_o, acc_o, acc_valid_o, busy_o, ovf_o
  );

  modport master (
    output start_i, len_i, prod_i, prod_valid_i, acc_ready_i,
    input  prod_ready_o, acc_o, acc_valid_o, busy_o, ovf_o
  );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// product_accumulator: sums a burst of 9-bit multiplier products with a sticky wrap flag.
// Revision: 1.0
`default_nettype none

module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int PAD_W = ACC_W - 9 + 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_prod_ready;
  logic             r_acc_valid;
  logic             r_busy;

  // One extra bit on the adder exposes the carry out of the accumulator.
  logic [ACC_W:0]   w_sum;
  assign w_sum = {1'b0, r_acc} + {{PAD_W{1'b0}}, bus.prod_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_len        <= bus.len_i;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_prod_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.prod_valid_i) begin
            r_acc <= w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) begin
              r_ovf <= 1'b1;
            end
            // Compare before incrementing so a full-length burst never wraps the count.
            if (r_cnt == r_len) begin
              r_prod_ready <= 1'b0;
              r_acc_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (bus.acc_ready_i) begin
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_prod_ready <= 1'b0;
          r_acc_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready_o = r_prod_ready;
  assign bus.acc_o        = r_acc;
  assign bus.acc_valid_o  = r_acc_valid;
  assign bus.busy_o       = r_busy;
  assign bus.ovf_o        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: 16-bit and 9-bit instances run the same bursts in lockstep.
// Revision: 1.0
`default_nettype none

module tb_product_accumulator;

  logic clk;
  logic rst_n;

  logic       t_start;
  logic [3:0] t_len;
  logic       t_valid;
  logic [8:0] t_prod;
  logic       t_rdy;

  product_accumulator_if #(.ACC_W(16), .CNT_W(4)) a_if ();
  product_accumulator_if #(.ACC_W(9),  .CNT_W(4)) b_if ();

  assign a_if.start_i      = t_start;
  assign a_if.len_i        = t_len;
  assign a_if.prod_i       = t_prod;
  assign a_if.prod_valid_i = t_valid;
  assign a_if.acc_ready_i  = t_rdy;
  assign b_if.start_i      = t_start;
  assign b_if.len_i        = t_len;
  assign b_if.prod_i       = t_prod;
  assign b_if.prod_valid_i = t_valid;
  assign b_if.acc_ready_i  = t_rdy;

  product_accumulator #(.ACC_W(16), .CNT_W(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  product_accumulator #(.ACC_W(9),  .CNT_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int stim[$];
  int qa_acc[$];
  int qa_ovf[$];
  int qb_acc[$];
  int qb_ovf[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: results are taken on the acc_valid/acc_ready handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.prod_valid_i && a_if.prod_ready_o) xfers++;
      if (a_if.acc_valid_o && qa_acc.size() == 0) begin
        check("spurious_result16", 32'(a_if.acc_valid_o), 32'd0);
      end else if (a_if.acc_valid_o && a_if.acc_ready_i) begin
        check("result_acc16", 32'(a_if.acc_o), 32'(qa_acc.pop_front()));
        check("result_ovf16", 32'(a_if.ovf_o), 32'(qa_ovf.pop_front()));
      end
      if (b_if.acc_valid_o && qb_acc.size() == 0) begin
        check("spurious_result9", 32'(b_if.acc_valid_o), 32'd0);
      end else if (b_if.acc_valid_o && b_if.acc_ready_i) begin
        check("result_acc9", 32'(b_if.acc_o), 32'(qb_acc.pop_front()));
        check("result_ovf9", 32'(b_if.ovf_o), 32'(qb_ovf.pop_front()));
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_acc16"},   32'(a_if.acc_o),        32'd0);
    check({nm, "_valid16"}, 32'(a_if.acc_valid_o),  32'd0);
    check({nm, "_ready16"}, 32'(a_if.prod_ready_o), 32'd0);
    check({nm, "_busy16"},  32'(a_if.busy_o),       32'd0);
    check({nm, "_ovf16"},   32'(a_if.ovf_o),        32'd0);
    check({nm, "_acc9"},    32'(b_if.acc_o),        32'd0);
    check({nm, "_ovf9"},    32'(b_if.ovf_o),        32'd0);
  endtask

  // Runs one burst of the products in stim; expected sums come from plain integer arithmetic.
  task automatic run_burst(input int len, input bit gaps, input bit hold_start);
    int sum;
    sum = 0;
    t_len   = 4'(len);
    t_start = 1'b1;
    tick();
    t_start = hold_start;
    t_len   = 4'($urandom);
    check("start_busy",   32'(a_if.busy_o), 32'd1);
    check("start_acc0",   32'(a_if.acc_o),  32'd0);
    check("start_ovf0_9", 32'(b_if.ovf_o),  32'd0);
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          t_valid = 1'b0;
          t_prod  = 9'($urandom);
          tick();
        end
      end
      check("prod_ready", 32'(a_if.prod_ready_o), 32'd1);
      sum += stim[i];
      if (i == len) begin
        qa_acc.push_back(sum % 65536);
        qa_ovf.push_back(sum >= 65536 ? 1 : 0);
        qb_acc.push_back(sum % 512);
        qb_ovf.push_back(sum >= 512 ? 1 : 0);
      end
      t_valid = 1'b1;
      t_prod  = 9'(stim[i]);
      tick();
    end
    t_valid = 1'b0;
    check("valid_zero_lat16", 32'(a_if.acc_valid_o),  32'd1);
    check("valid_zero_lat9",  32'(b_if.acc_valid_o),  32'd1);
    check("ready_off_done",   32'(a_if.prod_ready_o), 32'd0);
  endtask

  task automatic finish(input int hold, input bit noise, input bit st_hs);
    logic [31:0] held;
    held = 32'(a_if.acc_o);
    for (int k = 0; k < hold; k++) begin
      t_rdy   = 1'b0;
      t_valid = noise;
      t_prod  = 9'd255;
      tick();
      check("done_hold_acc",   32'(a_if.acc_o),       held);
      check("done_hold_valid", 32'(a_if.acc_valid_o), 32'd1);
    end
    t_rdy   = 1'b1;
    t_start = st_hs;
    tick();
    t_rdy   = 1'b0;
    t_start = 1'b0;
    t_valid = 1'b0;
    check("hs_valid_clr", 32'(a_if.acc_valid_o), 32'd0);
    check("hs_idle_busy", 32'(a_if.busy_o),      32'd0);
    check("hs_acc_keep",  32'(a_if.acc_o),       held);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    rst_n = 1'b0;
    t_start = 1'b0; t_len = '0; t_valid = 1'b0; t_prod = '0; t_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_after_reset", 32'(a_if.busy_o), 32'd0);

    // Basic burst 15+225+100.
    stim = '{15, 225, 100};
    run_burst(2, 1'b0, 1'b0);
    check("sum340",  32'(a_if.acc_o), 32'd340);
    check("ovf340",  32'(a_if.ovf_o), 32'd0);
    finish(0, 1'b0, 1'b0);

    // Wrap on the 9-bit instance: 675 mod 512.
    stim = '{225, 225, 225};
    run_burst(2, 1'b0, 1'b0);
    check("sum163_w9", 32'(b_if.acc_o), 32'd163);
    check("ovf_w9",    32'(b_if.ovf_o), 32'd1);
    check("sum675_w16", 32'(a_if.acc_o), 32'd675);
    finish(1, 1'b0, 1'b0);
    check("ovf_kept_idle_w9", 32'(b_if.ovf_o), 32'd1);

    // Single product held in DONE with stray valids.
    stim = '{9};
    run_burst(0, 1'b0, 1'b0);
    check("sum9", 32'(a_if.acc_o), 32'd9);
    finish(5, 1'b1, 1'b0);

    // Full-length burst with gaps.
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(225);
    x0 = xfers;
    run_burst(15, 1'b1, 1'b0);
    check("sum3600",   32'(a_if.acc_o), 32'd3600);
    check("sum16_w9",  32'(b_if.acc_o), 32'd16);
    check("xfers16",   32'(xfers - x0), 32'd16);
    finish(2, 1'b1, 1'b0);
    t_valid = 1'b1;
    t_prod  = 9'd200;
    repeat (3) tick();
    t_valid = 1'b0;
    check("idle_valid_ignored", 32'(a_if.acc_o), 32'd3600);

    // Async reset mid-burst.
    t_len = 4'd3; t_start = 1'b1;
    tick();
    t_start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      t_valid = 1'b1; t_prod = 9'(i);
      tick();
    end
    t_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle",  32'(a_if.busy_o),      32'd0);
    check("post_reset_valid", 32'(a_if.acc_valid_o), 32'd0);
    stim = '{1, 2, 3, 4};
    run_burst(3, 1'b0, 1'b0);
    check("sum10", 32'(a_if.acc_o), 32'd10);
    finish(0, 1'b0, 1'b0);

    // start_i held through ACCUM and the result handshake.
    stim = '{7, 8, 9};
    run_burst(2, 1'b1, 1'b1);
    check("held_start_sum", 32'(a_if.acc_o), 32'd24);
    finish(1, 1'b0, 1'b1);
    repeat (3) tick();
    check("held_start_idle",  32'(a_if.busy_o),       32'd0);
    check("held_start_ready", 32'(a_if.prod_ready_o), 32'd0);

    // Randomized bursts.
    for (int b = 0; b < 20; b++) begin
      int len;
      len = $urandom_range(0, 15);
      stim.delete();
      for (int i = 0; i <= len; i++) stim.push_back($urandom_range(0, 511));
      run_burst(len, 1'($urandom), 1'($urandom));
      finish($urandom_range(0, 3), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    check("queue16_empty", 32'(qa_acc.size()), 32'd0);
    check("queue9_empty",  32'(qb_acc.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
